seq_shift_right: RTL

Multi-cycle right-shift unit for the RISC-V datapath. It executes SRL/SRLI and SRA/SRAI by shifting one bit position per clock, which is the opposite direction to the existing shift-left-by-1 unit. A start/busy/done handshake lets the controller stall the datapath while the unit is busy. The final result is held on Output until the next accepted operation.

---
 rtl/seq_shift_right_pkg.sv | 11 +
 rtl/seq_shift_right_if.sv | 27 ++
 rtl/seq_shift_right_shr1_fill.sv | 14 +
 rtl/seq_shift_right.sv | 69 ++++++
 4 files changed

// File: rtl/seq_shift_right_pkg.sv
// Shared constants for the sequential right-shift unit: FSM encoding and default widths.
package seq_shift_right_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

endpackage

// File: rtl/seq_shift_right_if.sv
// Controller-facing start/busy/done bus of the sequential right-shift unit.
interface seq_shift_right_if
  import seq_shift_right_pkg::*;
#(
  parameter int N   = XLEN,
  parameter int SHW = SHAMT_W
);

  logic           start;
  logic [N-1:0]   D;
  logic [SHW-1:0] shamt;
  logic           arith;
  logic [N-1:0]   Output;
  logic           busy;
  logic           done;

  modport master (
    output start, D, shamt, arith,
    input  Output, busy, done
  );

  modport slave (
    input  start, D, shamt, arith,
    output Output, busy, done
  );

endinterface

// File: rtl/seq_shift_right_shr1_fill.sv
// Combinational single-step right shift by one, with the vacated MSB taken from a fill bit.
module shr1_fill
  import seq_shift_right_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic [N-1:0] i_d,
  input  logic         i_fill,
  output logic [N-1:0] o_q
);

  assign o_q = {i_fill, i_d[N-1:1]};

endmodule

// File: rtl/seq_shift_right.sv
// Multi-cycle SRL/SRA unit: shifts one bit per clock and holds the result until the next accept.
module seq_shift_right
  import seq_shift_right_pkg::*;
#(
  parameter int N   = XLEN,
  parameter int SHW = SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  seq_shift_right_if.slave   bus
);

  logic [1:0]     r_state;
  logic [N-1:0]   r_sreg;
  logic [SHW-1:0] r_cnt;
  logic           r_fill;
  logic [N-1:0]   r_out;

  logic [N-1:0]   w_shifted;

  shr1_fill #(.N(N)) u_shr1 (
    .i_d    (r_sreg),
    .i_fill (r_fill),
    .o_q    (w_shifted)
  );

  // Accepting from DONE as well as IDLE is what allows back-to-back operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_fill  <= 1'b0;
      r_out   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_sreg <= bus.D;
            r_cnt  <= bus.shamt;
            r_fill <= bus.arith & bus.D[N-1];
            if (bus.shamt == '0) begin
              r_out   <= bus.D;
              r_state <= S_DONE;
            end else begin
              r_state <= S_SHIFT;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_sreg <= w_shifted;
          r_cnt  <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_out   <= w_shifted;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Output = r_out;
  assign bus.busy   = (r_state == S_SHIFT);
  assign bus.done   = (r_state == S_DONE);

endmodule
